// File: rtl/sw_key_input.sv
// Switch/button conditioning for the picoMIPS core.
// Synchronises the raw inputs, debounces the key and latches SW when a press is accepted.
module sw_key_input #(
   parameter int n         = 8,
   parameter int DB_CYCLES = 500000
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [n-1:0] sw_raw,
   input  logic         key_n,
   output logic [n-1:0] SW,
   output logic         branch_status,
   output logic         press_pulse
);

   localparam int CW = $clog2(DB_CYCLES + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

   localparam logic [1:0] IDLE         = 2'd0;
   localparam logic [1:0] PRESS_WAIT   = 2'd1;
   localparam logic [1:0] PRESSED      = 2'd2;
   localparam logic [1:0] RELEASE_WAIT = 2'd3;

   logic [n-1:0]  sw_q1, sw_s;
   logic          key_q1, key_q2;
   logic          key_s;
   logic [1:0]    state, state_d;
   logic [CW-1:0] cnt, cnt_d;
   logic          accept;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sw_q1  <= '0;
         sw_s   <= '0;
         key_q1 <= 1'b1;
         key_q2 <= 1'b1;
      end else begin
         sw_q1  <= sw_raw;
         sw_s   <= sw_q1;
         key_q1 <= key_n;
         key_q2 <= key_q1;
      end
   end

   assign key_s = ~key_q2;

   // The counter restarts on every state entry, so it never needs to wrap.
   always_comb begin
      state_d = state;
      cnt_d   = cnt;
      accept  = 1'b0;
      case (state)
         IDLE: begin
            if (key_s) begin
               state_d = PRESS_WAIT;
               cnt_d   = '0;
            end
         end
         PRESS_WAIT: begin
            if (!key_s) begin
               state_d = IDLE;
            end else if (cnt == CNT_LAST) begin
               state_d = PRESSED;
               accept  = 1'b1;
            end else begin
               cnt_d = cnt + 1'b1;
            end
         end
         PRESSED: begin
            if (!key_s) begin
               state_d = RELEASE_WAIT;
               cnt_d   = '0;
            end
         end
         RELEASE_WAIT: begin
            if (key_s) begin
               state_d = PRESSED;
            end else if (cnt == CNT_LAST) begin
               state_d = IDLE;
            end else begin
               cnt_d = cnt + 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state         <= IDLE;
         cnt           <= '0;
         SW            <= '0;
         branch_status <= 1'b0;
         press_pulse   <= 1'b0;
      end else begin
         state         <= state_d;
         cnt           <= cnt_d;
         branch_status <= (state_d == PRESSED) || (state_d == RELEASE_WAIT);
         press_pulse   <= accept;
         if (accept) begin
            SW <= sw_s;
         end
      end
   end

endmodule

// File: tb/tb_sw_key_input.sv
// Bench for sw_key_input with DB_CYCLES=4.
// Expected presses are queued when the key is driven and retired on press_pulse.
module tb_sw_key_input;

   localparam int N  = 8;
   localparam int DB = 4;

   typedef struct {
      int         acc;
      logic [7:0] sw;
   } exp_t;

   logic         clk = 1'b0;
   logic         reset = 1'b0;
   logic [N-1:0] sw_raw = '0;
   logic         key_n = 1'b1;
   logic [N-1:0] SW;
   logic         branch_status;
   logic         press_pulse;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0;
   int n_pulse = 0;
   int n_push = 0;
   exp_t sb[$];

   sw_key_input #(.n(N), .DB_CYCLES(DB)) dut (
      .clk(clk),
      .reset(reset),
      .sw_raw(sw_raw),
      .key_n(key_n),
      .SW(SW),
      .branch_status(branch_status),
      .press_pulse(press_pulse)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, want %0h (cyc %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Key edge driven just after edge c is first sampled at c+1;
   // acceptance lands 2 sync stages plus DB counts later.
   task automatic push_press(input logic [7:0] sw);
      exp_t e;
      e.acc = cyc + 3 + DB;
      e.sw  = sw;
      sb.push_back(e);
      n_push++;
   endtask

   task automatic wait_sb(input int max);
      int k = 0;
      while (sb.size() != 0 && k < max) begin
         @(negedge clk);
         k++;
      end
      chk("sb_timeout", sb.size(), 0);
   endtask

   task automatic wait_cyc(input int target);
      int k = 0;
      @(negedge clk);
      while (cyc != target && k < 100) begin
         @(negedge clk);
         k++;
      end
      chk("wait_cyc", cyc, target);
   endtask

   always @(negedge clk) begin
      if (press_pulse) begin
         exp_t e;
         n_pulse++;
         if (sb.size() == 0) begin
            chk("spurious_pulse", 1, 0);
         end else begin
            e = sb.pop_front();
            chk("acc_cycle", cyc, e.acc);
            chk("sw_latch", SW, e.sw);
            chk("bs_at_pulse", branch_status, 1);
         end
      end
   end

   initial begin
      int acc, fall, p0;

      // held key and switches under reset
      key_n  = 1'b0;
      sw_raw = 8'hA5;
      repeat (4) begin
         @(negedge clk);
         chk("rst_sw", SW, 0);
         chk("rst_bs", branch_status, 0);
         chk("rst_pulse", press_pulse, 0);
      end
      tick();
      reset = 1'b1;
      push_press(8'hA5);
      wait_sb(20);
      key_n = 1'b1;
      repeat (10) tick();
      chk("rst_release_bs", branch_status, 0);

      // clean press
      sw_raw = 8'h3C;
      repeat (3) tick();
      key_n = 1'b0;
      acc = cyc + 3 + DB;
      push_press(8'h3C);
      wait_cyc(acc - 1);
      chk("pre_acc_bs", branch_status, 0);
      wait_cyc(acc);
      chk("acc_bs", branch_status, 1);
      chk("acc_pulse", press_pulse, 1);
      chk("acc_sw", SW, 8'h3C);
      @(negedge clk);
      chk("pulse_one_cycle", press_pulse, 0);
      chk("bs_held", branch_status, 1);

      // switch motion while pressed is ignored
      #1;
      sw_raw = 8'hFF;
      repeat (5) tick();
      chk("hold_sw", SW, 8'h3C);
      chk("hold_bs", branch_status, 1);
      key_n = 1'b1;
      repeat (10) tick();
      chk("rel_bs", branch_status, 0);
      chk("rel_sw", SW, 8'h3C);

      // next press picks up the new switches
      key_n = 1'b0;
      p0 = n_pulse;
      push_press(8'hFF);
      wait_sb(20);
      chk("next_sw", SW, 8'hFF);

      // release bounce: high 2, low 1, then high
      repeat (3) tick();
      key_n = 1'b1;
      tick();
      tick();
      key_n = 1'b0;
      tick();
      key_n = 1'b1;
      fall = cyc + 3 + DB;
      wait_cyc(fall - 1);
      chk("relb_bs_hold", branch_status, 1);
      wait_cyc(fall);
      chk("relb_bs_fall", branch_status, 0);
      chk("relb_pulses", n_pulse - p0, 1);
      chk("relb_sw", SW, 8'hFF);

      // short low runs are rejected
      sw_raw = 8'h5A;
      repeat (4) tick();
      p0 = n_pulse;
      repeat (5) begin
         key_n = 1'b0;
         repeat (3) tick();
         key_n = 1'b1;
         repeat (3) tick();
         chk("bounce_bs", branch_status, 0);
      end
      chk("bounce_pulses", n_pulse - p0, 0);
      key_n = 1'b0;
      push_press(8'h5A);
      wait_sb(20);
      chk("bounce_then_sw", SW, 8'h5A);
      key_n = 1'b1;
      repeat (10) tick();
      chk("bounce_rel_bs", branch_status, 0);

      // async reset in the middle of press debounce
      sw_raw = 8'h77;
      repeat (3) tick();
      key_n = 1'b0;
      acc = cyc + 5;
      while (cyc < acc) tick();
      #1;
      reset = 1'b0;
      #1;
      chk("async_sw", SW, 0);
      chk("async_bs", branch_status, 0);
      chk("async_pulse", press_pulse, 0);
      #1;
      reset = 1'b1;
      push_press(8'h77);
      wait_sb(20);
      chk("async_after_sw", SW, 8'h77);
      key_n = 1'b1;
      repeat (10) tick();

      chk("sb_empty", sb.size(), 0);
      chk("pulse_total", n_pulse, n_push);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, want finish");
      $fatal(1, "watchdog");
   end

endmodule
